// File: rtl/rs_ld_sd.sv
`default_nettype none
// ============================================================================
//  Module      : rs_ld_sd
//  Description : Reservation station for LD/SD address instructions. Holds
//                issued instructions until the base operand RY is available,
//                snoops the CDB for wakeup and release, and dispatches one
//                ready slot per cycle to the LD/SD address ULA.
//  Option      : define RS_OLDEST_FIRST_EN for oldest-first dispatch
//                (default build: lowest-index READY slot wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_ld_sd #(
   parameter int DATA_W  = 16,
   parameter int IMM_W   = 4,
   parameter int ENTRIES = 4    // 2..4: slot index travels as 2-bit RS position
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [2:0]        issue_op,
   input  logic [2:0]        issue_dest,
   input  logic [IMM_W-1:0]  issue_imm,
   input  logic              issue_ry_busy,
   input  logic [2:0]        issue_ry_reg,
   input  logic [DATA_W-1:0] issue_ry_data,
   input  logic [15:0]       cdb,
   output logic              issue_ack,
   output logic              rs_full,
   output logic [DATA_W-1:0] RY_data,
   output logic [IMM_W-1:0]  imediate,
   output logic [2:0]        reg_dest,
   output logic [2:0]        ULA_op,
   output logic [1:0]        RS_position,
   output logic              operands_ready
);

   localparam logic [15:0] c_CDB_IDLE = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_READY  = 2'd2,
      ST_ISSUED = 2'd3
   } slot_state_t;

   slot_state_t       r_state   [ENTRIES];
   logic [2:0]        r_op      [ENTRIES];
   logic [2:0]        r_dest    [ENTRIES];
   logic [IMM_W-1:0]  r_imm     [ENTRIES];
   logic [2:0]        r_ry_reg  [ENTRIES];
   logic [DATA_W-1:0] r_operand [ENTRIES];

   logic              w_cdb_valid;
   logic [DATA_W-1:0] w_cdb_value;
   logic              w_issue_bypass;
   logic              w_free_found;
   logic [1:0]        w_free_idx;
   logic              w_disp_found;
   logic [1:0]        w_disp_idx;

   // Register index (0..2) to its CDB one-hot tag; out-of-range indices never match
   function automatic logic [2:0] reg_onehot(input logic [2:0] idx);
      case (idx)
         3'd0:    reg_onehot = 3'b100;
         3'd1:    reg_onehot = 3'b010;
         3'd2:    reg_onehot = 3'b001;
         default: reg_onehot = 3'b000;
      endcase
   endfunction

   // CDB qualification: not idle and exactly one destination bit set
   always_comb begin
      w_cdb_valid    = (cdb != c_CDB_IDLE) &&
                       ((cdb[15:13] == 3'b100) || (cdb[15:13] == 3'b010) ||
                        (cdb[15:13] == 3'b001));
      w_cdb_value    = DATA_W'(cdb[9:0]);
      w_issue_bypass = w_cdb_valid && (reg_onehot(issue_ry_reg) == cdb[15:13]);
   end

   // Lowest-index FREE slot from registered state; a slot released this
   // cycle is therefore only visible from the next cycle on
   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = 2'd0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (r_state[i] == ST_FREE) begin
            w_free_found = 1'b1;
            w_free_idx   = 2'(i);
         end
      end
   end

   assign rs_full   = ~w_free_found;
   assign issue_ack = issue_valid & w_free_found;

`ifdef RS_OLDEST_FIRST_EN
   logic [1:0] r_age [ENTRIES];
   logic [1:0] w_best_age;

   // Oldest READY slot wins; strict compare keeps ties on the lowest index
   always_comb begin
      w_disp_found = 1'b0;
      w_disp_idx   = 2'd0;
      w_best_age   = 2'd0;
      for (int i = 0; i < ENTRIES; i++) begin
         if ((r_state[i] == ST_READY) && (!w_disp_found || (r_age[i] > w_best_age))) begin
            w_disp_found = 1'b1;
            w_disp_idx   = 2'(i);
            w_best_age   = r_age[i];
         end
      end
   end

   // Age tracking: new slot starts at 0, other occupied slots age on each allocation
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) r_age[i] <= 2'd0;
      end else if (issue_ack) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_free_idx == 2'(i))
               r_age[i] <= 2'd0;
            else if ((r_state[i] != ST_FREE) && (r_age[i] != 2'd3))
               r_age[i] <= r_age[i] + 2'd1;
         end
      end
   end
`else
   // Lowest-index READY slot wins
   always_comb begin
      w_disp_found = 1'b0;
      w_disp_idx   = 2'd0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (r_state[i] == ST_READY) begin
            w_disp_found = 1'b1;
            w_disp_idx   = 2'(i);
         end
      end
   end
`endif

   // Slot lifecycle (allocate, wake, dispatch, release) and registered dispatch outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_state[i]   <= ST_FREE;
            r_op[i]      <= 3'd0;
            r_dest[i]    <= 3'd0;
            r_imm[i]     <= '0;
            r_ry_reg[i]  <= 3'd0;
            r_operand[i] <= '0;
         end
         operands_ready <= 1'b0;
         RY_data        <= '0;
         imediate       <= '0;
         reg_dest       <= 3'd0;
         ULA_op         <= 3'd0;
         RS_position    <= 2'd0;
      end else begin
         operands_ready <= w_disp_found;
         for (int i = 0; i < ENTRIES; i++) begin
            case (r_state[i])
               ST_FREE: begin
                  if (issue_ack && (w_free_idx == 2'(i))) begin
                     r_op[i]     <= issue_op;
                     r_dest[i]   <= issue_dest;
                     r_imm[i]    <= issue_imm;
                     r_ry_reg[i] <= issue_ry_reg;
                     if (!issue_ry_busy) begin
                        r_state[i]   <= ST_READY;
                        r_operand[i] <= issue_ry_data;
                     end else if (w_issue_bypass) begin
                        r_state[i]   <= ST_READY;
                        r_operand[i] <= w_cdb_value;
                     end else begin
                        r_state[i]   <= ST_WAIT;
                     end
                  end
               end
               ST_WAIT: begin
                  if (w_cdb_valid && (reg_onehot(r_ry_reg[i]) == cdb[15:13])) begin
                     r_state[i]   <= ST_READY;
                     r_operand[i] <= w_cdb_value;
                  end
               end
               ST_READY: begin
                  if (w_disp_found && (w_disp_idx == 2'(i))) begin
                     r_state[i]  <= ST_ISSUED;
                     RY_data     <= r_operand[i];
                     imediate    <= r_imm[i];
                     reg_dest    <= r_dest[i];
                     ULA_op      <= r_op[i];
                     RS_position <= 2'(i);
                  end
               end
               ST_ISSUED: begin
                  // Only an LD/SD-ULA completion naming this slot frees it
                  if (w_cdb_valid && !cdb[10] && (cdb[12:11] == 2'(i)))
                     r_state[i] <= ST_FREE;
               end
               default: r_state[i] <= ST_FREE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rs_ld_sd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_ld_sd
//  Description : Self-checking bench for rs_ld_sd: per-cycle directed vectors
//                plus an asynchronous mid-dispatch reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_ld_sd;

   localparam logic [15:0] c_IDLE = 16'hFFFF;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [2:0]  issue_op;
   logic [2:0]  issue_dest;
   logic [3:0]  issue_imm;
   logic        issue_ry_busy;
   logic [2:0]  issue_ry_reg;
   logic [15:0] issue_ry_data;
   logic [15:0] cdb;
   logic        issue_ack;
   logic        rs_full;
   logic [15:0] RY_data;
   logic [3:0]  imediate;
   logic [2:0]  reg_dest;
   logic [2:0]  ULA_op;
   logic [1:0]  RS_position;
   logic        operands_ready;

   always #5 clock = ~clock;

   rs_ld_sd dut (
      .clock          (clock),
      .reset          (reset),
      .issue_valid    (issue_valid),
      .issue_op       (issue_op),
      .issue_dest     (issue_dest),
      .issue_imm      (issue_imm),
      .issue_ry_busy  (issue_ry_busy),
      .issue_ry_reg   (issue_ry_reg),
      .issue_ry_data  (issue_ry_data),
      .cdb            (cdb),
      .issue_ack      (issue_ack),
      .rs_full        (rs_full),
      .RY_data        (RY_data),
      .imediate       (imediate),
      .reg_dest       (reg_dest),
      .ULA_op         (ULA_op),
      .RS_position    (RS_position),
      .operands_ready (operands_ready)
   );

   typedef struct packed {
      logic        iv;
      logic [2:0]  op;
      logic [2:0]  dest;
      logic [3:0]  imm;
      logic        busy;
      logic [2:0]  ry_reg;
      logic [15:0] ry_data;
      logic [15:0] cdb;
   } in_t;

   typedef struct packed {
      logic        ack;
      logic        full;
      logic        rdy;
      logic        chk;     // compare data outputs (dispatch or hold)
      logic [15:0] data;
      logic [3:0]  imm;
      logic [2:0]  dest;
      logic [2:0]  op;
      logic [1:0]  pos;
   } exp_t;

   typedef struct packed {
      in_t  in;
      exp_t ex;
   } vec_t;

   vec_t vecs[$];
   vec_t v;
   int   n_checks = 0;
   int   n_errors = 0;
   int   vid = 0;

   function automatic in_t ISS(input logic [2:0] op, input logic [2:0] dest, input logic [3:0] imm,
                               input logic busy, input logic [2:0] ry_reg, input logic [15:0] ry_data,
                               input logic [15:0] c);
      ISS = '{iv: 1'b1, op: op, dest: dest, imm: imm, busy: busy, ry_reg: ry_reg, ry_data: ry_data, cdb: c};
   endfunction

   function automatic in_t CDB(input logic [15:0] c);
      CDB = '{iv: 1'b0, op: 3'd0, dest: 3'd0, imm: 4'h0, busy: 1'b0, ry_reg: 3'd0, ry_data: 16'h0, cdb: c};
   endfunction

   function automatic exp_t NR(input logic ack, input logic full);
      NR = '{ack: ack, full: full, rdy: 1'b0, chk: 1'b0, data: 16'h0, imm: 4'h0, dest: 3'd0, op: 3'd0, pos: 2'd0};
   endfunction

   function automatic exp_t DSP(input logic ack, input logic full, input logic [15:0] data, input logic [3:0] imm,
                                input logic [2:0] dest, input logic [2:0] op, input logic [1:0] pos);
      DSP = '{ack: ack, full: full, rdy: 1'b1, chk: 1'b1, data: data, imm: imm, dest: dest, op: op, pos: pos};
   endfunction

   function automatic exp_t HOLD(input logic ack, input logic full, input logic [15:0] data, input logic [3:0] imm,
                                 input logic [2:0] dest, input logic [2:0] op, input logic [1:0] pos);
      HOLD = '{ack: ack, full: full, rdy: 1'b0, chk: 1'b1, data: data, imm: imm, dest: dest, op: op, pos: pos};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (vector %0d, t=%0t): got %h, expected %h", name, vid, $time, act, exp);
      end
   endtask

   task automatic drive(input in_t i);
      issue_valid   = i.iv;
      issue_op      = i.op;
      issue_dest    = i.dest;
      issue_imm     = i.imm;
      issue_ry_busy = i.busy;
      issue_ry_reg  = i.ry_reg;
      issue_ry_data = i.ry_data;
      cdb           = i.cdb;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " operands_ready"}, 16'(operands_ready), 16'h0);
      check({tag, " rs_full"},        16'(rs_full),        16'h0);
      check({tag, " RY_data"},        RY_data,             16'h0);
      check({tag, " imediate"},       16'(imediate),       16'h0);
      check({tag, " reg_dest"},       16'(reg_dest),       16'h0);
      check({tag, " ULA_op"},         16'(ULA_op),         16'h0);
      check({tag, " RS_position"},    16'(RS_position),    16'h0);
   endtask

   initial begin
      reset = 1'b1;
      drive(CDB(c_IDLE));

      // Ready issue, second ready issue, release and ULA-producer non-release
      vecs.push_back('{ISS(3'd3, 3'd1, 4'h5, 1'b0, 3'd0, 16'h0020, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{ISS(3'd7, 3'd2, 4'hA, 1'b0, 3'd0, 16'h1234, c_IDLE), DSP(1'b1, 1'b0, 16'h0020, 4'h5, 3'd1, 3'd3, 2'd0)});
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b0, 16'h1234, 4'hA, 3'd2, 3'd7, 2'd1)});
      vecs.push_back('{CDB(16'b010_01_1_0000000001),                        HOLD(1'b0, 1'b0, 16'h1234, 4'hA, 3'd2, 3'd7, 2'd1)});
      vecs.push_back('{CDB(16'b010_00_0_0000100101),                        NR(1'b0, 1'b0)});
      // Wakeup: lands in freed slot 0, slot 1 still held
      vecs.push_back('{ISS(3'd1, 3'd0, 4'h3, 1'b1, 3'd2, 16'h0000, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{CDB(16'b001_01_1_0000001010),                        NR(1'b0, 1'b0)});
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b0, 16'h000A, 4'h3, 3'd0, 3'd1, 2'd0)});
      // Same-cycle bypass into slot 2, then an invalid two-hot CDB naming slot 0
      vecs.push_back('{ISS(3'd2, 3'd2, 4'h7, 1'b1, 3'd0, 16'h0000, 16'b100_10_1_0000000111), NR(1'b1, 1'b0)});
      vecs.push_back('{CDB(16'b110_00_0_0000000000),                        DSP(1'b0, 1'b0, 16'h0007, 4'h7, 3'd2, 3'd2, 2'd2)});
      vecs.push_back('{ISS(3'd5, 3'd0, 4'hC, 1'b0, 3'd0, 16'h0ABC, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{CDB(16'b100_00_0_0000000000),                        DSP(1'b0, 1'b1, 16'h0ABC, 4'hC, 3'd0, 3'd5, 2'd3)});
      vecs.push_back('{CDB(16'b100_01_0_0000000000),                        NR(1'b0, 1'b0)});
      vecs.push_back('{CDB(16'b100_10_0_0000000000),                        NR(1'b0, 1'b0)});
      vecs.push_back('{CDB(16'b100_11_0_0000000000),                        NR(1'b0, 1'b0)});
      // Fill, rejected issue held, wake/dispatch/release slot 2, retry lands in slot 2
      vecs.push_back('{ISS(3'd0, 3'd0, 4'h1, 1'b1, 3'd0, 16'h0000, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{ISS(3'd1, 3'd1, 4'h2, 1'b1, 3'd0, 16'h0000, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{ISS(3'd4, 3'd2, 4'h4, 1'b1, 3'd2, 16'h0000, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{ISS(3'd5, 3'd0, 4'h8, 1'b1, 3'd0, 16'h0000, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{ISS(3'd6, 3'd1, 4'hF, 1'b0, 3'd0, 16'h0055, c_IDLE), NR(1'b0, 1'b1)});
      vecs.push_back('{ISS(3'd6, 3'd1, 4'hF, 1'b0, 3'd0, 16'h0055, 16'b001_11_1_0000010000), NR(1'b0, 1'b1)});
      vecs.push_back('{ISS(3'd6, 3'd1, 4'hF, 1'b0, 3'd0, 16'h0055, c_IDLE), DSP(1'b0, 1'b1, 16'h0010, 4'h4, 3'd2, 3'd4, 2'd2)});
      vecs.push_back('{ISS(3'd6, 3'd1, 4'hF, 1'b0, 3'd0, 16'h0055, 16'b001_10_0_0000000000), NR(1'b0, 1'b1)});
      vecs.push_back('{ISS(3'd6, 3'd1, 4'hF, 1'b0, 3'd0, 16'h0055, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b1, 16'h0055, 4'hF, 3'd1, 3'd6, 2'd2)});
      // Three slots wake on one edge and drain in index order
      vecs.push_back('{CDB(16'b100_00_1_0000000011),                        HOLD(1'b0, 1'b1, 16'h0055, 4'hF, 3'd1, 3'd6, 2'd2)});
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b1, 16'h0003, 4'h1, 3'd0, 3'd0, 2'd0)});
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b1, 16'h0003, 4'h2, 3'd1, 3'd1, 2'd1)});
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b1, 16'h0003, 4'h8, 3'd0, 3'd5, 2'd3)});
      vecs.push_back('{CDB(16'b100_00_0_0000000000),                        NR(1'b0, 1'b1)});
      vecs.push_back('{CDB(16'b100_01_0_0000000000),                        NR(1'b0, 1'b0)});
      vecs.push_back('{CDB(16'b100_10_0_0000000000),                        NR(1'b0, 1'b0)});
      vecs.push_back('{CDB(16'b100_11_0_0000000000),                        NR(1'b0, 1'b0)});
      // Arbitration: slot 3 allocated before slot 1 is reused, both wake together
      vecs.push_back('{ISS(3'd0, 3'd0, 4'h0, 1'b1, 3'd0, 16'h0000, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{ISS(3'd1, 3'd1, 4'h1, 1'b0, 3'd0, 16'h0011, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{ISS(3'd2, 3'd2, 4'h2, 1'b1, 3'd0, 16'h0000, c_IDLE), DSP(1'b1, 1'b0, 16'h0011, 4'h1, 3'd1, 3'd1, 2'd1)});
      vecs.push_back('{ISS(3'd3, 3'd0, 4'h3, 1'b1, 3'd1, 16'h0000, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{CDB(16'b001_01_0_0000000000),                        NR(1'b0, 1'b1)});
      vecs.push_back('{ISS(3'd4, 3'd1, 4'h4, 1'b1, 3'd1, 16'h0000, c_IDLE), NR(1'b1, 1'b0)});
      vecs.push_back('{CDB(16'b010_00_1_0000001001),                        NR(1'b0, 1'b1)});
`ifdef RS_OLDEST_FIRST_EN
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b1, 16'h0009, 4'h3, 3'd0, 3'd3, 2'd3)});
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b1, 16'h0009, 4'h4, 3'd1, 3'd4, 2'd1)});
`else
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b1, 16'h0009, 4'h4, 3'd1, 3'd4, 2'd1)});
      vecs.push_back('{CDB(c_IDLE),                                         DSP(1'b0, 1'b1, 16'h0009, 4'h3, 3'd0, 3'd3, 2'd3)});
`endif

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check_outputs_zero("reset");
      check("reset issue_ack", 16'(issue_ack), 16'h0);
      reset = 1'b0;

      // Per-cycle vectors: combinational outputs before the edge, registered after
      for (int k = 0; k < vecs.size(); k++) begin
         vid = k + 1;
         v   = vecs[k];
         drive(v.in);
         #2;
         check("issue_ack", 16'(issue_ack), 16'(v.ex.ack));
         check("rs_full",   16'(rs_full),   16'(v.ex.full));
         @(posedge clock);
         #1;
         check("operands_ready", 16'(operands_ready), 16'(v.ex.rdy));
         if (v.ex.chk) begin
            check("RY_data",     RY_data,           v.ex.data);
            check("imediate",    16'(imediate),     16'(v.ex.imm));
            check("reg_dest",    16'(reg_dest),     16'(v.ex.dest));
            check("ULA_op",      16'(ULA_op),       16'(v.ex.op));
            check("RS_position", 16'(RS_position),  16'(v.ex.pos));
         end
      end

      // Asynchronous reset in the middle of a dispatch strobe, away from any edge
      vid = 100;
      drive(CDB(c_IDLE));
      #1;
      reset = 1'b1;
      #1;
      check_outputs_zero("async reset");
      @(posedge clock);
      #1;
      reset = 1'b0;

      // A completion for a discarded slot must not revive anything
      vid = 101;
      drive(CDB(16'b010_00_0_0000000011));
      repeat (2) begin
         @(posedge clock);
         #1;
         check("post-reset operands_ready", 16'(operands_ready), 16'h0);
         check("post-reset rs_full",        16'(rs_full),        16'h0);
         check("post-reset RY_data",        RY_data,             16'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rs_ld_sd.md
Name: rs_ld_sd

Overview:
- Reservation station for load/store address instructions.
- Sits directly upstream of the LD/SD address ULA: accepts issued LD/SD instructions, holds them until the base operand RY is available, then dispatches one ready entry per cycle.
- Snoops the 16-bit CDB to wake up waiting operands and to release entries whose address result has been broadcast.

Parameters:
- DATA_W, 16, operand width on the dispatch side.
- IMM_W, 4, immediate width.
- ENTRIES, 4, number of station slots; legal range 2..4 because the slot index travels as a 2-bit RS position.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- issue_valid  in  1  issue request this cycle
- issue_op  in  3  operation code, passed through to dispatch
- issue_dest  in  3  destination register index (0..2)
- issue_imm  in  IMM_W  immediate offset
- issue_ry_busy  in  1  1 = RY not yet produced; wait on CDB
- issue_ry_reg  in  3  RY register index (0..2), used when busy
- issue_ry_data  in  DATA_W  RY value, used when not busy
- cdb  in  16  CDB snoop:
  - [15:13] one-hot destination register (R0=100, R1=010, R2=001)
  - [12:11] RS position
  - [10] producer (1=ULA, 0=LD/SD ULA)
  - [9:0] data
  - 16'hFFFF = idle
- issue_ack  out  1  combinational; issue accepted this cycle
- rs_full  out  1  combinational; no free slot
- RY_data  out  DATA_W  dispatched base operand
- imediate  out  IMM_W  dispatched immediate
- reg_dest  out  3  dispatched destination index
- ULA_op  out  3  dispatched op
- RS_position  out  2  dispatched slot index
- operands_ready  out  1  one-cycle dispatch strobe

Behaviour:
- Per-slot state: FREE, WAIT, READY, ISSUED. Each slot also holds op, dest, imm, ry_reg and a 16-bit operand.
- Reset (async, any time, including mid-dispatch):
  - All slots go FREE.
  - operands_ready=0; RY_data, imediate, reg_dest, ULA_op and RS_position all 0.
  - Any in-flight state is discarded; a later CDB completion for a discarded slot is ignored because the slot is FREE.
- CDB valid = (cdb != 16'hFFFF) and exactly one bit of cdb[15:13] is set. Invalid or idle words cause no action.
- Allocation:
  - The free slot is the lowest-index FREE slot, judged from registered state.
  - rs_full = no FREE slot.
  - issue_ack = issue_valid & ~rs_full.
  - An issue while full is dropped with ack=0; the issuer must hold the request and retry.
  - The new slot is written at the clock edge.
- Operand state on allocation:
  - ry_busy=0: slot enters READY with operand = issue_ry_data.
  - ry_busy=1 and a valid CDB in the same cycle whose one-hot bit matches issue_ry_reg: bypass. Slot enters READY with operand = {6'b0, cdb[9:0]}.
  - Otherwise the slot enters WAIT.
- Wakeup:
  - Every WAIT slot whose ry_reg matches the valid CDB one-hot captures {6'b0, cdb[9:0]} and goes READY on that edge.
  - Multiple slots may wake on the same edge.
- Dispatch:
  - Each cycle, select one READY slot (lowest index by default).
  - Outputs are registered: 1-cycle latency from READY to operands_ready=1.
  - Output fields carry the slot contents, with RS_position = slot index.
  - The slot goes ISSUED on the same edge.
  - When no slot is selected: operands_ready=0 and the data outputs hold their last values.
  - A slot that becomes READY on edge N can dispatch at the earliest on edge N+1.
- Release:
  - A valid CDB with cdb[10]=0 and cdb[12:11]=k, where slot k is ISSUED, sets slot k to FREE.
  - A completion naming a slot that is not ISSUED is ignored.
  - A freed slot is allocatable from the next cycle. rs_full deasserts the cycle after release.
- Simultaneous events:
  - Release of slot k and allocation in the same cycle cannot collide, because allocation only picks slots that are already FREE.
  - Wakeup and dispatch in the same cycle: the woken slot is not eligible until the next cycle.

Optional Feature:
- Macro: RS_OLDEST_FIRST_EN.
- Defined:
  - Each slot keeps a 2-bit age, set to 0 on allocation.
  - The ages of all other occupied slots increment (saturating at 3) on each allocation.
  - Dispatch selects the READY slot with the greatest age; ties go to the lowest index.
- Undefined: no age storage; dispatch selects the lowest-index READY slot.

Test Plan:
- Reset mid-run: 3 slots occupied (1 ISSUED), assert reset asynchronously → rs_full=0, operands_ready=0 immediately, all outputs 0; a subsequent CDB 16'b010_00_0_0000000011 causes no dispatch.
- Ready issue:
  - Stimulus: issue op=3'b011, dest=1, imm=4'h5, ry_busy=0, ry_data=16'h0020.
  - Response: next edge operands_ready=1 with RY_data=16'h0020, imediate=5, reg_dest=1, RS_position=0; slot stays occupied until CDB 16'b010_00_0_0000100101 frees it.
- Wakeup: issue ry_busy=1, ry_reg=2 into slot 0; drive CDB 16'b001_01_1_0000001010 → slot READY, dispatch one cycle later with RY_data=16'h000A.
- Same-cycle bypass: issue ry_busy=1, ry_reg=0 while the CDB carries 16'b100_10_1_0000000111 → no WAIT cycle; dispatch next edge with RY_data=16'h0007.
- Full/retry:
  - Fill 4 slots with ry_busy=1 → rs_full=1; a 5th issue gets issue_ack=0.
  - Wake and dispatch slot 2, then broadcast CDB position 2, ULA=0 → rs_full=0 next cycle.
  - Retried issue lands in slot 2.
- Arbitration: slots 1 and 3 become READY on the same edge → default dispatches slot 1 first then slot 3; with RS_OLDEST_FIRST_EN, where slot 3 was allocated earlier, slot 3 dispatches first.
